// File: rtl/pipe_control.sv
// Pipelined RV32I control: decodes in D, carries control through E/M/W, raises stall/flush/forward selects.
// Decode and hazard outputs are combinational; E/M/W fields lag D by 1/2/3 edges; load-use and MUL hold freeze F/D (MUL also E).
module pipe_control #(
    parameter int ALUCTRL_W = 4,
    parameter int ENABLE_M  = 1,
    parameter int MUL_LAT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr_d,
    input  logic                 pc_src_e,
    output logic [2:0]           imm_src_d,
    output logic                 illegal_d,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic [ALUCTRL_W-1:0] alu_ctrl_e,
    output logic                 alu_src_e,
    output logic                 branch_e,
    output logic                 jump_e,
    output logic                 jalr_e,
    output logic [2:0]           funct3_e,
    output logic [4:0]           rs1_e,
    output logic [4:0]           rs2_e,
    output logic [4:0]           rd_e,
    output logic [1:0]           fwd_a_e,
    output logic [1:0]           fwd_b_e,
    output logic                 mem_write_m,
    output logic [2:0]           funct3_m,
    output logic                 reg_write_m,
    output logic [4:0]           rd_m,
    output logic                 reg_write_w,
    output logic [1:0]           result_src_w,
    output logic [4:0]           rd_w
);

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_write;
        logic                 branch;
        logic                 jump;
        logic                 jalr;
        logic                 alu_src;
        logic                 is_load;
        logic                 is_mul;
        logic [1:0]           result_src;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic [2:0]           funct3;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
    } ex_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic [2:0] funct3;
        logic [4:0] rd;
    } mem_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic [4:0] rd;
    } wb_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(9);
    localparam logic [ALUCTRL_W-1:0] ALU_PASB = ALUCTRL_W'(10);
    localparam logic [ALUCTRL_W-1:0] ALU_MUL  = ALUCTRL_W'(11);

    localparam int              CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    ex_t              e_q, e_d, dec;
    mem_t             m_q, m_d;
    wb_t              w_q, w_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [2:0] dec_imm;
    logic       dec_illegal, rs1_used, rs2_used;
    logic       mul_hold, load_use;

    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign funct7 = instr_d[31:25];

    always_comb begin
        dec         = '0;
        dec_imm     = 3'b000;
        dec_illegal = 1'b0;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                rs1_used      = 1'b1;
                case (funct3)
                    3'b000: dec.alu_ctrl = ALU_ADD;
                    3'b010: dec.alu_ctrl = ALU_SLT;
                    3'b011: dec.alu_ctrl = ALU_SLTU;
                    3'b100: dec.alu_ctrl = ALU_XOR;
                    3'b110: dec.alu_ctrl = ALU_OR;
                    3'b111: dec.alu_ctrl = ALU_AND;
                    3'b001: begin
                        dec.alu_ctrl = ALU_SLL;
                        dec_illegal  = (funct7 != 7'h00);
                    end
                    default: begin
                        dec.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                        dec_illegal  = (funct7 != 7'h00) && (funct7 != 7'h20);
                    end
                endcase
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                if (funct7 == 7'h01) begin
                    dec.is_mul   = 1'b1;
                    dec.alu_ctrl = ALU_MUL;
                    dec_illegal  = (ENABLE_M == 0) || (funct3 != 3'b000);
                end else if (funct7 == 7'h00) begin
                    case (funct3)
                        3'b000:  dec.alu_ctrl = ALU_ADD;
                        3'b001:  dec.alu_ctrl = ALU_SLL;
                        3'b010:  dec.alu_ctrl = ALU_SLT;
                        3'b011:  dec.alu_ctrl = ALU_SLTU;
                        3'b100:  dec.alu_ctrl = ALU_XOR;
                        3'b101:  dec.alu_ctrl = ALU_SRL;
                        3'b110:  dec.alu_ctrl = ALU_OR;
                        default: dec.alu_ctrl = ALU_AND;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    dec.alu_ctrl = ALU_SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
                    dec.alu_ctrl = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.is_load    = 1'b1;
                dec.result_src = 2'b01;
                rs1_used       = 1'b1;
                dec_illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec_imm       = 3'b001;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                dec_illegal   = (funct3[2] || funct3 == 3'b011);
            end
            OPC_BRANCH: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                dec_imm      = 3'b010;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                dec_illegal  = (funct3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                dec_imm        = 3'b011;
            end
            OPC_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
                rs1_used       = 1'b1;
                dec_illegal    = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALU_PASB;
                dec_imm       = 3'b100;
            end
            OPC_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec_imm       = 3'b100;
            end
            default: dec_illegal = 1'b1;
        endcase
        dec.funct3 = funct3;
        dec.rs1    = rs1_used ? instr_d[19:15] : 5'd0;
        dec.rs2    = rs2_used ? instr_d[24:20] : 5'd0;
        dec.rd     = dec.reg_write ? instr_d[11:7] : 5'd0;
        if (dec_illegal) begin
            dec     = '0;
            dec_imm = 3'b000;
        end
    end

    // Unused rs fields are already zero, and rd_e != 0, so they can never match.
    assign mul_hold = e_q.is_mul && (mul_cnt_q < CNT_LAST);
    assign load_use = !mul_hold && e_q.is_load && (e_q.rd != 5'd0) &&
                      ((dec.rs1 == e_q.rd) || (dec.rs2 == e_q.rd));

    always_comb begin
        e_d       = dec;
        mul_cnt_d = '0;
        if (pc_src_e) begin
            e_d = '0;
        end else if (mul_hold) begin
            e_d       = e_q;
            mul_cnt_d = mul_cnt_q + CNT_W'(1);
        end else if (load_use) begin
            e_d = '0;
        end

        m_d.reg_write  = e_q.reg_write;
        m_d.mem_write  = e_q.mem_write;
        m_d.result_src = e_q.result_src;
        m_d.funct3     = e_q.funct3;
        m_d.rd         = e_q.rd;
        if (mul_hold && !pc_src_e) begin
            m_d = '0;
        end

        w_d.reg_write  = m_q.reg_write;
        w_d.result_src = m_q.result_src;
        w_d.rd         = m_q.rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            mul_cnt_q <= '0;
        end else begin
            e_q       <= e_d;
            m_q       <= m_d;
            w_q       <= w_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (m_q.reg_write && m_q.rd != 5'd0 && m_q.rd == e_q.rs1)      fwd_a_e = 2'b10;
        else if (w_q.reg_write && w_q.rd != 5'd0 && w_q.rd == e_q.rs1) fwd_a_e = 2'b01;
        if (m_q.reg_write && m_q.rd != 5'd0 && m_q.rd == e_q.rs2)      fwd_b_e = 2'b10;
        else if (w_q.reg_write && w_q.rd != 5'd0 && w_q.rd == e_q.rs2) fwd_b_e = 2'b01;
    end

    assign imm_src_d    = dec_imm;
    assign illegal_d    = dec_illegal;
    assign flush_d      = pc_src_e;
    assign stall_f      = !pc_src_e && (mul_hold || load_use);
    assign stall_d      = stall_f;
    assign alu_ctrl_e   = e_q.alu_ctrl;
    assign alu_src_e    = e_q.alu_src;
    assign branch_e     = e_q.branch;
    assign jump_e       = e_q.jump;
    assign jalr_e       = e_q.jalr;
    assign funct3_e     = e_q.funct3;
    assign rs1_e        = e_q.rs1;
    assign rs2_e        = e_q.rs2;
    assign rd_e         = e_q.rd;
    assign mem_write_m  = m_q.mem_write;
    assign funct3_m     = m_q.funct3;
    assign reg_write_m  = m_q.reg_write;
    assign rd_m         = m_q.rd;
    assign reg_write_w  = w_q.reg_write;
    assign result_src_w = w_q.result_src;
    assign rd_w         = w_q.rd;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: hand-encoded RV32I sequences with hand-derived stage/hazard values.
module tb_pipe_control;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ADDI1 = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] LW2   = 32'h0000_A103; // lw   x2,0(x1)
    localparam logic [31:0] ADD3  = 32'h0021_01B3; // add  x3,x2,x2
    localparam logic [31:0] ADD4  = 32'h0010_8233; // add  x4,x1,x1
    localparam logic [31:0] SUB5  = 32'h4042_02B3; // sub  x5,x4,x4
    localparam logic [31:0] BEQ   = 32'h0000_0063; // beq  x0,x0,0
    localparam logic [31:0] SW    = 32'h0020_A223; // sw   x2,4(x1)
    localparam logic [31:0] JAL   = 32'h0000_80EF; // jal  x1,0x8000
    localparam logic [31:0] LUI   = 32'h0000_83B7; // lui  x7,0x8
    localparam logic [31:0] SRAI  = 32'h4030_D093; // srai x1,x1,3
    localparam logic [31:0] MUL6  = 32'h0220_8333; // mul  x6,x1,x2

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_d;
    logic        pc_src_e;

    logic [2:0] imm_src_d, funct3_e, funct3_m;
    logic       illegal_d, stall_f, stall_d, flush_d, alu_src_e, branch_e, jump_e, jalr_e;
    logic [3:0] alu_ctrl_e;
    logic [4:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] fwd_a_e, fwd_b_e, result_src_w;
    logic       mem_write_m, reg_write_m, reg_write_w;

    logic [2:0] imm_src_n, funct3_e_n, funct3_m_n;
    logic       illegal_n, stall_f_n, stall_d_n, flush_n, alu_src_n, branch_n, jump_n, jalr_n;
    logic [3:0] alu_ctrl_n;
    logic [4:0] rs1_n, rs2_n, rd_e_n, rd_m_n, rd_w_n;
    logic [1:0] fwd_a_n, fwd_b_n, result_src_n;
    logic       mem_write_n, reg_write_m_n, reg_write_w_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_control #(.ALUCTRL_W(4), .ENABLE_M(1), .MUL_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_src_e(pc_src_e),
        .imm_src_d(imm_src_d), .illegal_d(illegal_d), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e), .branch_e(branch_e),
        .jump_e(jump_e), .jalr_e(jalr_e), .funct3_e(funct3_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_write_m(mem_write_m),
        .funct3_m(funct3_m), .reg_write_m(reg_write_m), .rd_m(rd_m), .reg_write_w(reg_write_w),
        .result_src_w(result_src_w), .rd_w(rd_w)
    );

    pipe_control #(.ALUCTRL_W(4), .ENABLE_M(0), .MUL_LAT(3)) dut_nm (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_src_e(pc_src_e),
        .imm_src_d(imm_src_n), .illegal_d(illegal_n), .stall_f(stall_f_n), .stall_d(stall_d_n),
        .flush_d(flush_n), .alu_ctrl_e(alu_ctrl_n), .alu_src_e(alu_src_n), .branch_e(branch_n),
        .jump_e(jump_n), .jalr_e(jalr_n), .funct3_e(funct3_e_n), .rs1_e(rs1_n), .rs2_e(rs2_n),
        .rd_e(rd_e_n), .fwd_a_e(fwd_a_n), .fwd_b_e(fwd_b_n), .mem_write_m(mem_write_n),
        .funct3_m(funct3_m_n), .reg_write_m(reg_write_m_n), .rd_m(rd_m_n), .reg_write_w(reg_write_w_n),
        .result_src_w(result_src_n), .rd_w(rd_w_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] instr, input logic pc_src);
        instr_d  = instr;
        pc_src_e = pc_src;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        instr_d  = NOP;
        pc_src_e = 1'b0;
        #12;
        chk("rst_rd_e", rd_e, 0);
        chk("rst_alu_e", alu_ctrl_e, 0);
        chk("rst_regw_m", reg_write_m, 0);
        chk("rst_regw_w", reg_write_w, 0);
        chk("rst_stall_f", stall_f, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5 walks E -> M -> W
        set_in(ADDI1, 0);
        chk("addi_imm", imm_src_d, 3'b000);
        chk("addi_ill", illegal_d, 0);
        tick();
        chk("addi_alu_e", alu_ctrl_e, 0);
        chk("addi_src_e", alu_src_e, 1);
        chk("addi_rd_e", rd_e, 1);
        set_in(NOP, 0);
        tick();
        chk("addi_regw_m", reg_write_m, 1);
        chk("addi_rd_m", rd_m, 1);
        tick();
        chk("addi_regw_w", reg_write_w, 1);
        chk("addi_rd_w", rd_w, 1);
        chk("addi_res_w", result_src_w, 2'b00);

        // load-use: one stall cycle, bubble, then Writeback forwarding
        set_in(LW2, 0);
        chk("lw_nostall", stall_f, 0);
        tick();
        chk("lw_rd_e", rd_e, 2);
        set_in(ADD3, 0);
        chk("lu_stall_f", stall_f, 1);
        chk("lu_stall_d", stall_d, 1);
        chk("lu_flush", flush_d, 0);
        tick();
        chk("lu_bubble_rd_e", rd_e, 0);
        chk("lu_rd_m", rd_m, 2);
        chk("lu_stall_once", stall_f, 0);
        tick();
        chk("lu_add_rd_e", rd_e, 3);
        chk("lu_fwd_a", fwd_a_e, 2'b01);
        chk("lu_fwd_b", fwd_b_e, 2'b01);

        // Memory forwarding, no stall, SUB selection
        set_in(ADD4, 0);
        chk("alu_nostall", stall_f, 0);
        tick();
        set_in(SUB5, 0);
        chk("sub_nostall", stall_f, 0);
        tick();
        chk("sub_fwd_a", fwd_a_e, 2'b10);
        chk("sub_fwd_b", fwd_b_e, 2'b10);
        chk("sub_alu", alu_ctrl_e, 1);

        // flush beats a pending load-use stall
        set_in(LW2, 0);
        tick();
        set_in(ADD3, 1);
        chk("fl_flush", flush_d, 1);
        chk("fl_stall_f", stall_f, 0);
        chk("fl_stall_d", stall_d, 0);
        tick();
        chk("fl_bubble_rd_e", rd_e, 0);
        chk("fl_lw_rd_m", rd_m, 2);

        // real branch in Execute, then flushed
        set_in(BEQ, 0);
        chk("beq_imm", imm_src_d, 3'b010);
        tick();
        chk("beq_branch_e", branch_e, 1);
        set_in(NOP, 1);
        chk("beq_flush", flush_d, 1);
        tick();
        chk("beq_bubble", branch_e, 0);

        // immediate formats and unused-field masking
        set_in(SW, 0);
        chk("sw_imm", imm_src_d, 3'b001);
        tick();
        chk("sw_rs2_e", rs2_e, 2);
        chk("sw_rd_e", rd_e, 0);
        set_in(JAL, 0);
        chk("jal_imm", imm_src_d, 3'b011);
        tick();
        chk("jal_jump_e", jump_e, 1);
        chk("jal_rs1_e", rs1_e, 0);
        set_in(LUI, 0);
        chk("lui_imm", imm_src_d, 3'b100);
        tick();
        chk("lui_alu", alu_ctrl_e, 10);
        chk("lui_rs1_e", rs1_e, 0);
        set_in(SRAI, 0);
        tick();
        chk("srai_alu", alu_ctrl_e, 7);
        chk("srai_src", alu_src_e, 1);

        // MUL hold: two stall cycles, bubbles into M, MUL reaches M on the third edge
        set_in(ADD4, 0);
        tick();
        set_in(MUL6, 0);
        chk("mul_ill", illegal_d, 0);
        chk("mul_ill_nom", illegal_n, 1);
        tick();
        chk("mul_alu", alu_ctrl_e, 11);
        chk("mul_prev_m", reg_write_m, 1);
        set_in(NOP, 0);
        chk("mul_stall0", stall_f, 1);
        tick();
        chk("mul_hold1_rd_e", rd_e, 6);
        chk("mul_hold1_regw_m", reg_write_m, 0);
        chk("mul_stall1", stall_f, 1);
        tick();
        chk("mul_hold2_rd_e", rd_e, 6);
        chk("mul_hold2_regw_m", reg_write_m, 0);
        chk("mul_stall2", stall_f, 0);
        tick();
        chk("mul_m_regw", reg_write_m, 1);
        chk("mul_m_rd", rd_m, 6);
        chk("mul_e_next", rd_e, 0);

        // illegal instruction becomes a bubble
        set_in(ADD4, 0);
        tick();
        set_in(32'hFFFF_FFFF, 0);
        chk("ill_flag", illegal_d, 1);
        tick();
        chk("ill_rd_e", rd_e, 0);
        set_in(NOP, 0);
        tick();
        chk("ill_regw_m", reg_write_m, 0);

        // asynchronous reset in the middle of a MUL hold
        set_in(MUL6, 0);
        tick();
        set_in(NOP, 0);
        tick();
        chk("mr_held", stall_f, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rd_e", rd_e, 0);
        chk("mr_stall", stall_f, 0);
        chk("mr_regw_m", reg_write_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mr_after_stall", stall_f, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
